// File: rtl/bcd_up_counter_if.sv
// Output bundle of one BCD digit stage: the four count bits plus terminal count.
interface bcd_up_counter_if;
   logic Qa;
   logic Qb;
   logic Qc;
   logic Qd;
   logic tc;

   // The counter drives the bundle; a downstream stage or observer reads it.
   modport master (output Qa, Qb, Qc, Qd, tc);
   modport slave  (input  Qa, Qb, Qc, Qd, tc);
endinterface

// File: rtl/bcd_up_counter.sv
// Single decade (BCD) digit counter: counts 0..9 on every clock, wraps to 0,
// and flags terminal count (9) so a following digit stage can be cascaded.
module bcd_up_counter (
   input  logic               clk,
   input  logic               clr,
   bcd_up_counter_if.master   cnt
);

   logic [3:0] count_q;
   logic [3:0] count_d;

   // Next-state: increment below 9; 9 and any illegal code (10..15) go to 0.
   always_comb begin
      count_d = 4'd0;
      if (count_q < 4'd9) begin
         count_d = count_q + 4'd1;
      end
   end

   // All four bits share one clock; clr clears without waiting for an edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // Q comes straight from the flops; tc decodes 1001 exactly.
   assign cnt.Qa = count_q[0];
   assign cnt.Qb = count_q[1];
   assign cnt.Qc = count_q[2];
   assign cnt.Qd = count_q[3];
   assign cnt.tc = (count_q == 4'd9);

endmodule

// File: tb/tb_bcd_up_counter.sv
// Bench for bcd_up_counter: directed scenarios followed by randomized clock and
// clear activity, all checked against an integer decade model.
module tb_bcd_up_counter;

   logic clk;
   logic clr;
   int   n_total;
   int   n_bad;
   int   m;          // model count value 0..9

   bcd_up_counter_if cnt_if ();

   bcd_up_counter dut (
      .clk (clk),
      .clr (clr),
      .cnt (cnt_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] q_now();
      return {1'b0, cnt_if.Qd, cnt_if.Qc, cnt_if.Qb, cnt_if.Qa};
   endfunction

   // Compare DUT outputs to the model's current value.
   task automatic check_model(input string tag);
      check_val({tag, "_q"}, q_now(), 5'(m));
      check_val({tag, "_tc"}, {4'd0, cnt_if.tc}, {4'd0, (m == 9)});
   endtask

   // One clock edge: advance the model by the counter's rules, then check.
   task automatic tick(input string tag);
      @(posedge clk);
      if (clr) m = (m + 1) % 10;
      else     m = 0;
      #1;
      check_model(tag);
   endtask

   // Run until the model reaches target (bounded: at most one full decade).
   task automatic run_to(input int target);
      int k;
      k = 0;
      while (m != target && k < 12) begin
         tick("run");
         k++;
      end
      check_val("run_to_reached", 5'(m), 5'(target));
   endtask

   // Clear asserted between edges must zero the count immediately.
   task automatic mid_clear(input string tag, input int hold_edges);
      @(negedge clk);
      #2;
      clr = 1'b0;
      m = 0;
      #1;
      check_model({tag, "_imm"});
      for (int i = 0; i < hold_edges; i++) tick({tag, "_hold"});
      @(negedge clk);
      clr = 1'b1;
      #1;
      check_model({tag, "_rel"});
   endtask

   // Place the register in an illegal code while the true count is 9, so the
   // following edge must yield 0 whichever value the register resumes with.
   task automatic illegal_state(input string tag, input logic [3:0] code);
      run_to(9);
      #2;
      force dut.count_q = code;
      #1;
      check_val({tag, "_q"}, q_now(), {1'b0, code});
      check_val({tag, "_tc"}, {4'd0, cnt_if.tc}, 5'd0);
      @(negedge clk);
      release dut.count_q;
      tick({tag, "_recover"});
      tick({tag, "_next"});
   endtask

   initial begin
      int wraps;
      int max_seen;
      int prev;
      n_total = 0;
      n_bad   = 0;
      m       = 0;

      // Power-up: clear held low across two edges.
      clr = 1'b0;
      #1;
      check_model("reset_t1");
      tick("reset_edge1");
      tick("reset_edge2");

      // Release between edges: no change until the next clock.
      @(negedge clk);
      clr = 1'b1;
      #1;
      check_model("release_noedge");

      // Twelve edges: 1..9, 0, 1, 2 with exactly one wrap.
      wraps    = 0;
      max_seen = 0;
      for (int i = 0; i < 12; i++) begin
         prev = int'(q_now());
         tick("seq");
         if (prev == 9 && q_now() == 5'd0) wraps++;
         if (int'(q_now()) > max_seen) max_seen = int'(q_now());
      end
      check_val("seq_wraps", 5'(wraps), 5'd1);
      check_val("seq_max", 5'(max_seen), 5'd9);
      check_val("seq_end", q_now(), 5'd2);

      // Clear mid-period at 6, held across an edge; next edge after release gives 1.
      run_to(6);
      mid_clear("clr_at6", 1);
      tick("after_clr6");
      check_val("after_clr6_one", q_now(), 5'd1);

      // Clear while terminal count is active.
      run_to(9);
      check_val("tc_at9", {4'd0, cnt_if.tc}, 5'd1);
      mid_clear("clr_at9", 0);

      // Illegal states self-recover in one clock.
      illegal_state("ill_12", 4'd12);
      illegal_state("ill_15", 4'd15);

      // Randomized run: mostly counting, occasional mid-period clears.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            mid_clear("rnd_clr", int'($urandom_range(0, 2)));
         end else begin
            tick("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
